// File: rtl/sqrt_req_scheduler.sv
// sqrt_req_scheduler: shares one square-root core between N_REQ requesters.
// One request in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// A watchdog in WAIT clears the core and returns a flagged zero response.
// Optional macro SQRT_SCHED_ROUND_ROBIN_EN: rotating priority when defined,
// fixed lowest-index-wins priority otherwise.
module sqrt_req_scheduler #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 16,
  parameter int BUF_BIT_W   = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int ID_W        = $clog2(N_REQ)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_REQ-1:0]                      req_valid_i,
  input  logic [N_REQ*(2*DATA_W+BUF_BIT_W)-1:0] req_data_i,
  output logic [N_REQ-1:0]                      req_ready_o,
  output logic [2*DATA_W+BUF_BIT_W-1:0]         sqrt_din_o,
  output logic                                  sqrt_din_update_o,
  output logic                                  sqrt_clr_o,
  input  logic [DATA_W-1:0]                     sqrt_dout_i,
  input  logic                                  sqrt_dout_update_i,
  output logic                                  rsp_valid_o,
  input  logic                                  rsp_ready_i,
  output logic [ID_W-1:0]                       rsp_id_o,
  output logic [DATA_W-1:0]                     rsp_data_o,
  output logic                                  rsp_timeout_o,
  output logic                                  busy_o
);
  localparam int IN_W  = 2*DATA_W + BUF_BIT_W;
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [IN_W-1:0]   din_q, din_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_to_q, rsp_to_d;
  logic [ID_W-1:0]   rr_ptr;
  logic              sqrt_clr;

  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W:0]     cand;
  logic [N_REQ-1:0]  gnt_vec;

`ifdef SQRT_SCHED_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  // Next search start moves past the requester whose response was just taken.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == S_RESP && rsp_ready_i)
      rr_ptr_d = (gid_q == ID_W'(N_REQ - 1)) ? '0 : gid_q + 1'b1;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = '0;
`endif

  // Arbiter: first valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    gnt_vec   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) cand = cand - (ID_W+1)'(N_REQ);
      if (!gnt_found && req_valid_i[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[ID_W-1:0];
      end
    end
    if (gnt_found && state_q == S_IDLE && !rst) gnt_vec[gnt_idx] = 1'b1;
  end

  // FSM next-state, operand latch, watchdog timer and response capture.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    din_d       = din_q;
    gid_d       = gid_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_to_d    = rsp_to_q;
    sqrt_clr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          din_d   = req_data_i[gnt_idx*IN_W +: IN_W];
          gid_d   = gnt_idx;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A result arriving on the expiry cycle still wins over the watchdog.
        if (sqrt_dout_update_i) begin
          rsp_data_d  = sqrt_dout_i;
          rsp_to_d    = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (timer_q == TMR_LAST) begin
          sqrt_clr    = 1'b1;
          rsp_data_d  = '0;
          rsp_to_d    = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      din_q       <= '0;
      gid_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      din_q       <= din_d;
      gid_q       <= gid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  // Combinational outputs are forced low while reset is asserted.
  assign req_ready_o       = gnt_vec;
  assign sqrt_din_update_o = (state_q == S_ISSUE) && !rst;
  assign sqrt_clr_o        = sqrt_clr && !rst;
  assign busy_o            = (state_q != S_IDLE) && !rst;
  assign sqrt_din_o        = din_q;
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_id_o          = gid_q;
  assign rsp_data_o        = rsp_data_q;
  assign rsp_timeout_o     = rsp_to_q;

endmodule

// File: tb/tb_sqrt_req_scheduler.sv
// Bench for sqrt_req_scheduler: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_sqrt_req_scheduler;
  localparam int N_REQ       = 4;
  localparam int DATA_W      = 16;
  localparam int BUF_BIT_W   = 8;
  localparam int TIMEOUT_CYC = 32;
  localparam int ID_W        = $clog2(N_REQ);
  localparam int IN_W        = 2*DATA_W + BUF_BIT_W;
  localparam int CORE_LAT    = 18;  // launch pulse to result strobe
`ifdef SQRT_SCHED_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_REQ-1:0]      req_valid_i;
  logic [N_REQ*IN_W-1:0] req_data_i;
  logic [N_REQ-1:0]      req_ready_o;
  logic [IN_W-1:0]       sqrt_din_o;
  logic                  sqrt_din_update_o;
  logic                  sqrt_clr_o;
  logic [DATA_W-1:0]     sqrt_dout_i;
  logic                  sqrt_dout_update_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [ID_W-1:0]       rsp_id_o;
  logic [DATA_W-1:0]     rsp_data_o;
  logic                  rsp_timeout_o;
  logic                  busy_o;

  always #5 clk = ~clk;

  sqrt_req_scheduler #(.N_REQ(N_REQ), .DATA_W(DATA_W), .BUF_BIT_W(BUF_BIT_W),
                       .TIMEOUT_CYC(TIMEOUT_CYC), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .sqrt_din_o(sqrt_din_o),
    .sqrt_din_update_o(sqrt_din_update_o), .sqrt_clr_o(sqrt_clr_o),
    .sqrt_dout_i(sqrt_dout_i), .sqrt_dout_update_i(sqrt_dout_update_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_data_o(rsp_data_o), .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] isqrt(input longint unsigned x);
    longint unsigned r = 0;
    longint unsigned t;
    for (int b = DATA_W-1; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t*t <= x) r = t;
    end
    return DATA_W'(r);
  endfunction

  // Reference arbitration: scan upward from ptr with wrap, first valid wins.
  function automatic logic [N_REQ-1:0] pick(input logic [N_REQ-1:0] v, input int ptr);
    logic [N_REQ-1:0] g = '0;
    bit f = 1'b0;
    int idx;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (ptr + i) % N_REQ;
      if (!f && v[idx]) begin g[idx] = 1'b1; f = 1'b1; end
    end
    return g;
  endfunction

  // Core stub: answers CORE_LAT cycles after the launch pulse unless disabled;
  // 'inject' forces a stray strobe carrying junk data.
  bit                pend = 1'b0;
  int                due = 0;
  logic [DATA_W-1:0] pval = '0;
  bit                stub_en = 1'b1;
  bit                inject = 1'b0;

  initial begin
    sqrt_dout_update_i = 1'b0;
    sqrt_dout_i = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (stub_en && pend && cyc == due) begin
        sqrt_dout_update_i = 1'b1;
        sqrt_dout_i = pval;
        pend = 1'b0;
      end else begin
        sqrt_dout_update_i = inject;
        sqrt_dout_i = inject ? DATA_W'(16'h5a5a) : DATA_W'($urandom);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (sqrt_din_update_o) begin
      pend = 1'b1;
      due = cyc + CORE_LAT;
      pval = isqrt(64'(sqrt_din_o));
    end
  end

  // Reference model state: one transaction in flight.
  typedef struct { int id; int data; bit to; } rsp_t;
  rsp_t              log_q[$];
  bit                m_busy = 1'b0;
  int                m_ptr = 0;
  int                t_a, t_gid, t_rsp;
  bit                t_to;
  logic [IN_W-1:0]   t_op;
  logic [DATA_W-1:0] t_exp;
  logic [N_REQ-1:0]  exp_g;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_ready", 64'(req_ready_o), 0);
      chk("rst_busy", 64'(busy_o), 0);
      chk("rst_upd", 64'(sqrt_din_update_o), 0);
      chk("rst_clr", 64'(sqrt_clr_o), 0);
      m_busy = 1'b0;
      m_ptr = 0;
    end else begin
      chk("busy", 64'(busy_o), 64'(m_busy));
      if (!m_busy) begin
        exp_g = pick(req_valid_i, m_ptr);
        chk("grant", 64'(req_ready_o), 64'(exp_g));
        chk("rsp_idle", 64'(rsp_valid_o), 0);
        chk("upd_idle", 64'(sqrt_din_update_o), 0);
        chk("clr_idle", 64'(sqrt_clr_o), 0);
        if (exp_g != '0) begin
          for (int k = 0; k < N_REQ; k++) if (exp_g[k]) t_gid = k;
          m_busy = 1'b1;
          t_a = cyc;
          t_op = req_data_i[t_gid*IN_W +: IN_W];
          t_exp = isqrt(64'(t_op));
          t_to = !stub_en;
          t_rsp = t_to ? cyc + 2 + TIMEOUT_CYC : cyc + 20;
        end
      end else begin
        chk("ready_busy", 64'(req_ready_o), 0);
        chk("upd", 64'(sqrt_din_update_o), 64'(cyc == t_a + 1));
        chk("clr", 64'(sqrt_clr_o), 64'(t_to && cyc == t_a + 1 + TIMEOUT_CYC));
        if (cyc == t_a + 1) chk("din", 64'(sqrt_din_o), 64'(t_op));
        chk("rsp_valid", 64'(rsp_valid_o), 64'(cyc >= t_rsp));
        if (cyc >= t_rsp) begin
          chk("rsp_id", 64'(rsp_id_o), 64'(t_gid));
          chk("rsp_data", 64'(rsp_data_o), t_to ? 64'd0 : 64'(t_exp));
          chk("rsp_to", 64'(rsp_timeout_o), 64'(t_to));
          if (rsp_ready_i) begin
            log_q.push_back('{id: t_gid, data: int'(rsp_data_o), to: rsp_timeout_o});
            m_busy = 1'b0;
            if (RR) m_ptr = (t_gid + 1) % N_REQ;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [IN_W-1:0] v);
    req_data_i[k*IN_W +: IN_W] = v;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (m_busy && k < budget) begin step(); k++; end
    chk("wait_idle", 64'(m_busy), 0);
  endtask

  task automatic wait_rsp(input int budget);
    int k = 0;
    while (!rsp_valid_o && k < budget) begin step(); k++; end
    chk("wait_rsp", 64'(rsp_valid_o), 1);
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin step(); k++; end
    chk("wait_log", 64'(log_q.size() >= n), 1);
  endtask

  int base, n1;
  int exp_id[4];
  int root_of[4];

  initial begin
    rst = 1'b1; req_valid_i = '1; req_data_i = '0; rsp_ready_i = 1'b0;
    repeat (3) step();
    rst = 1'b0; req_valid_i = '0;
    step();
    chk("rst_rsp_valid", 64'(rsp_valid_o), 0);
    chk("rst_din", 64'(sqrt_din_o), 0);
    chk("rst_rsp_data", 64'(rsp_data_o), 0);
    chk("rst_rsp_id", 64'(rsp_id_o), 0);
    chk("rst_rsp_to", 64'(rsp_timeout_o), 0);

    // Single request from requester 2.
    rsp_ready_i = 1'b1;
    set_data(2, 40'd1000000);
    req_valid_i = 4'b0100;
    step();
    req_valid_i = '0;
    wait_idle(100);
    chk("single_id", 64'(log_q[$].id), 2);
    chk("single_data", 64'(log_q[$].data), 1000);
    chk("single_to", 64'(log_q[$].to), 0);

    // Contention: 0, 1 and 3 held valid for four transactions.
    set_data(0, 40'd144); set_data(1, 40'd400); set_data(3, 40'd10000);
    root_of = '{12, 20, 0, 100};
    exp_id = RR ? '{0, 1, 3, 0} : '{0, 0, 0, 0};
    base = log_q.size();
    req_valid_i = 4'b1011;
    wait_log(base + 4, 200);
    req_valid_i = '0;
    wait_idle(100);
    n1 = 0;
    for (int i = 0; i < 4; i++) begin
      chk("cont_id", 64'(log_q[base+i].id), 64'(exp_id[i]));
      chk("cont_data", 64'(log_q[base+i].data), 64'(root_of[exp_id[i]]));
      if (log_q[base+i].id == 1) n1++;
    end
    chk("cont_req1_grants", 64'(n1), RR ? 64'd1 : 64'd0);

    // Watchdog: core never answers, then stray strobes are ignored.
    stub_en = 1'b0; rsp_ready_i = 1'b0;
    set_data(1, 40'd50);
    req_valid_i = 4'b0010;
    step();
    req_valid_i = '0;
    wait_rsp(60);
    inject = 1'b1;
    repeat (3) step();
    rsp_ready_i = 1'b1;
    repeat (4) step();
    inject = 1'b0;
    stub_en = 1'b1;
    wait_idle(10);
    chk("to_data", 64'(log_q[$].data), 0);
    chk("to_flag", 64'(log_q[$].to), 1);
    chk("to_id", 64'(log_q[$].id), 1);

    // Backpressure for 10 cycles with another requester waiting.
    rsp_ready_i = 1'b0;
    set_data(3, 40'd4000000); set_data(0, 40'd81);
    req_valid_i = 4'b1000;
    step();
    req_valid_i = 4'b0001;
    wait_rsp(40);
    repeat (10) step();
    rsp_ready_i = 1'b1;
    step();
    req_valid_i = '0;
    chk("bp_idle", 64'(busy_o), 0);
    chk("bp_data", 64'(log_q[$].data), 2000);

    // Reset in the middle of WAIT abandons the request.
    base = log_q.size();
    set_data(2, 40'd2500);
    req_valid_i = 4'b0100;
    step();
    req_valid_i = '0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rsp_valid", 64'(rsp_valid_o), 0);
    chk("mid_din", 64'(sqrt_din_o), 0);
    chk("mid_busy", 64'(busy_o), 0);
    chk("mid_rsp_id", 64'(rsp_id_o), 0);
    repeat (15) step();
    chk("mid_no_rsp", 64'(log_q.size()), 64'(base));
    set_data(0, 40'd49); set_data(3, 40'd64);
    req_valid_i = 4'b1001;
    #1 chk("mid_regrant", 64'(req_ready_o), 64'b0001);
    step();
    req_valid_i = '0;
    wait_idle(100);
    chk("mid_next_data", 64'(log_q[$].data), 7);

    // Random traffic.
    base = log_q.size();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N_REQ; k++) begin
        req_valid_i[k] = ($urandom_range(0, 9) < 4);
        set_data(k, {8'd0, 32'($urandom)});
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    wait_idle(100);
    chk("rand_count", 64'(log_q.size() - base >= 20), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/sqrt_req_scheduler.md
# sqrt_req_scheduler

Round-robin scheduler that shares one `square_root` unit between several RMS channel requesters (for example V-RMS and I-RMS accumulators). It accepts one request at a time and launches it on the square-root core. It returns the result, tagged with the requester id, through a valid/ready response port. A watchdog clears the core and returns a flagged zero if the core never answers.

## Interface
- `N_REQ`, 4: number of requesters (≥2).
- `DATA_W`, 16: root width; matches the square-root core.
- `BUF_BIT_W`, 8: extra accumulator headroom bits; operand width `IN_W = 2*DATA_W+BUF_BIT_W`.
- `TIMEOUT_CYC`, 64: maximum WAIT cycles before the watchdog fires; must be ≥ 20.
- `ID_W`, `$clog2(N_REQ)`: response tag width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid_i` in `N_REQ`: per-requester request valid.
- `req_data_i` in `N_REQ*IN_W`: flattened operands; requester k owns bits `[k*IN_W +: IN_W]`.
- `req_ready_o` out `N_REQ`: one-hot grant; asserted only in IDLE.
- `sqrt_din_o` out `IN_W`: operand to the core (registered).
- `sqrt_din_update_o` out 1: one-cycle launch pulse.
- `sqrt_clr_o` out 1: one-cycle core clear on timeout.
- `sqrt_dout_i` in `DATA_W`: core result.
- `sqrt_dout_update_i` in 1: core result strobe.
- `rsp_valid_o` out 1: response valid; held until accepted.
- `rsp_ready_i` in 1: response consumer ready.
- `rsp_id_o` out `ID_W`: requester index of the response.
- `rsp_data_o` out `DATA_W`: root, or 0 on timeout.
- `rsp_timeout_o` out 1: response produced by the watchdog.
- `busy_o` out 1: high in every state except IDLE.

## Operation
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE:**
  - Arbiter picks winner g among set `req_valid_i` bits.
  - Search starts at `rr_ptr` and goes upward with wrap-around.
  - `req_ready_o[g]` is driven combinationally.
  - On handshake: latch operand into `sqrt_din_o`, latch g, go to ISSUE.
  - No valid request: stay in IDLE.
- **ISSUE:** `sqrt_din_update_o`=1 for exactly one cycle; timer cleared to 0; go to WAIT.
- **WAIT:** timer increments each cycle.
  - `sqrt_dout_update_i`=1: capture `sqrt_dout_i` into `rsp_data_o`, set `rsp_timeout_o`=0, set `rsp_valid_o`, go to RESP.
  - Otherwise, if timer == `TIMEOUT_CYC-1`: `sqrt_clr_o`=1 for one cycle, `rsp_data_o`=0, `rsp_timeout_o`=1, set `rsp_valid_o`, go to RESP.
  - Result strobe and timeout expiry in the same cycle: the result wins and no clear is issued.
- **RESP:**
  - Outputs held stable while `rsp_ready_i`=0.
  - On `rsp_valid_o && rsp_ready_i`: clear `rsp_valid_o`, set `rr_ptr` to (g+1) mod `N_REQ`, go to IDLE.
  - A new grant can happen in the cycle after acceptance.
- `sqrt_dout_update_i` outside WAIT is ignored; a stale result is never forwarded.
- `req_valid_i` deasserting while not granted is legal; no state is kept per requester.

## Timing
- Reset values, applied while `rst`=1 at a clock edge:
  - state IDLE, `rr_ptr`=0, timer=0.
  - All outputs 0, including `req_ready_o`; `rst` overrides the IDLE grant.
- Reset mid-operation abandons the request with no response; the pending core result is ignored.
- Throughput: one request per ≥4 cycles plus core latency.
- Latency with the 16-iteration core:
  - Handshake in cycle A; `sqrt_din_update_o` in cycle A+1.
  - Core strobe in cycle A+19; `rsp_valid_o` visible in cycle A+20.
- Timeout path: `sqrt_clr_o` in cycle A+1+`TIMEOUT_CYC`; `rsp_valid_o` in the following cycle.

## Configuration
- `SQRT_SCHED_ROUND_ROBIN_EN`:
  - Defined: rotating priority as described above.
  - Undefined: fixed priority, lowest index wins; `rr_ptr` logic removed and treated as constant 0.

## Test plan
- Single request: requester 2 sends 1 000 000 → `rsp_valid_o` at A+20, `rsp_id_o`=2, `rsp_data_o`=1000, `rsp_timeout_o`=0.
- Contention (round-robin): requesters 0, 1 and 3 held valid with 144, 400 and 10000 → responses in order id 0/12, 1/20, 3/100; then id 0 again only after id 3.
- Contention with macro undefined: requester 0 held continuously valid with 144 while requester 1 also requests → requester 1 is never granted.
- Timeout: core stub never strobes, `TIMEOUT_CYC`=32 → one `sqrt_clr_o` pulse at A+33; response `rsp_data_o`=0, `rsp_timeout_o`=1; late strobe after that is ignored.
- Backpressure: `rsp_ready_i`=0 for 10 cycles after `rsp_valid_o` → id/data stable, `req_ready_o` stays 0, `busy_o`=1; accepted on the first ready cycle, IDLE on the next.
- Reset mid-WAIT: `rst` pulsed in cycle A+10 → no response; all outputs 0; next request completes normally with grant from index 0.
